// File: rtl/answer_poller.sv
// answer_poller
//   Initiator for the answer-table responder. Each frame walks the table
//   addresses 0..LAST_ADDR and waits out the responder's registered-read
//   latency. It latches each data byte and hands it to a UART transmitter
//   using a level strobe (ValTX). The far end synchronises ValTX with two
//   flops, so the strobe is held high for VAL_CYC cycles and then low for at
//   least VAL_CYC cycles.
//   Address 0 carries the responder's frame counter. The poller checks that
//   this counter advances by exactly one per completed frame. The check
//   treats 255 -> 0 as a valid step.
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active low
//   start       1-cycle pulse: begin one frame (ignored while busy)
//   tx_busy     UART transmitter busy; holds off the next strobe
//   data[7:0]   registered table data from responder
//   addr[4:0]   table address to responder
//   oUART[7:0]  byte to UART transmitter, stable while ValTX is high
//   ValTX       byte strobe, high VAL_CYC cycles
//   busy        frame in progress
//   frame_done  1-cycle pulse after the final byte's gap
//   cnt_err     sticky: addr-0 counter did not advance by one
//
// Build option
//   POLL_CHECKSUM_EN: when this is defined, one extra byte follows the
//   LAST_ADDR byte. That byte is the XOR of all table bytes in the frame.
//   While it is sent, addr stays at LAST_ADDR.

module answer_poller #(
  parameter int LAST_ADDR = 17,
  parameter int RD_LAT    = 1,
  parameter int VAL_CYC   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       tx_busy,
  input  logic [7:0] data,
  output logic [4:0] addr,
  output logic [7:0] oUART,
  output logic       ValTX,
  output logic       busy,
  output logic       frame_done,
  output logic       cnt_err
);

  localparam int VW = $clog2(VAL_CYC + 1);
  localparam int WW = $clog2(RD_LAT + 1);
  localparam logic [VW-1:0] VAL_LAST  = VW'(VAL_CYC - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(RD_LAT - 1);
  localparam logic [4:0]    ADDR_LAST = 5'(LAST_ADDR);

  typedef enum logic [2:0] {
    S_IDLE, S_SETADDR, S_WAIT, S_LATCH, S_TXWAIT, S_STROBE, S_GAP, S_DONE
  } state_t;

  state_t        state_reg;
  logic [VW-1:0] cyc_reg;          // strobe-high / gap-low cycle counter
  logic [WW-1:0] wait_reg;         // read-latency counter
  logic [7:0]    prev_cnt_reg;     // responder counter seen last frame
  logic          first_frame_reg;  // no previous counter to compare against
`ifdef POLL_CHECKSUM_EN
  logic [7:0]    xsum_reg;
  logic          sum_phase_reg;    // checksum byte is the one in flight
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= S_IDLE;
      cyc_reg         <= '0;
      wait_reg        <= '0;
      prev_cnt_reg    <= 8'd0;
      first_frame_reg <= 1'b1;
      addr            <= 5'd0;
      oUART           <= 8'd0;
      ValTX           <= 1'b0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      cnt_err         <= 1'b0;
`ifdef POLL_CHECKSUM_EN
      xsum_reg        <= 8'd0;
      sum_phase_reg   <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            addr      <= 5'd0;
            state_reg <= S_SETADDR;
`ifdef POLL_CHECKSUM_EN
            xsum_reg      <= 8'd0;
            sum_phase_reg <= 1'b0;
`endif
          end
        end

        S_SETADDR: begin
          wait_reg  <= '0;
          state_reg <= S_WAIT;
        end

        S_WAIT: begin
          if (wait_reg == WAIT_LAST) state_reg <= S_LATCH;
          else                       wait_reg  <= wait_reg + 1'b1;
        end

        S_LATCH: begin
          oUART <= data;
`ifdef POLL_CHECKSUM_EN
          xsum_reg <= xsum_reg ^ data;
`endif
          // The 8-bit compare wraps, so 255 -> 0 counts as a valid step.
          if (addr == 5'd0) begin
            if (!first_frame_reg && (data != prev_cnt_reg + 8'd1))
              cnt_err <= 1'b1;
            prev_cnt_reg <= data;
          end
          state_reg <= S_TXWAIT;
        end

        S_TXWAIT: begin
          if (!tx_busy) begin
            ValTX     <= 1'b1;
            cyc_reg   <= '0;
            state_reg <= S_STROBE;
          end
        end

        S_STROBE: begin
          if (cyc_reg == VAL_LAST) begin
            ValTX     <= 1'b0;
            cyc_reg   <= '0;
            state_reg <= S_GAP;
          end else begin
            cyc_reg <= cyc_reg + 1'b1;
          end
        end

        S_GAP: begin
          if (cyc_reg == VAL_LAST) begin
            if (addr != ADDR_LAST) begin
              addr      <= addr + 5'd1;
              state_reg <= S_SETADDR;
            end
`ifdef POLL_CHECKSUM_EN
            else if (!sum_phase_reg) begin
              // addr stays at LAST_ADDR so the responder sees no extra read.
              oUART         <= xsum_reg;
              sum_phase_reg <= 1'b1;
              state_reg     <= S_TXWAIT;
            end
`endif
            else begin
              frame_done <= 1'b1;
              state_reg  <= S_DONE;
            end
          end else begin
            cyc_reg <= cyc_reg + 1'b1;
          end
        end

        S_DONE: begin
          busy            <= 1'b0;
          first_frame_reg <= 1'b0;
          addr            <= 5'd0;
          state_reg       <= S_IDLE;
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_answer_poller.sv
// Directed bench for answer_poller with a registered-read responder model.
module tb_answer_poller;

  localparam int VAL_CYC = 4;
`ifdef POLL_CHECKSUM_EN
  localparam int FLEN = 19;
`else
  localparam int FLEN = 18;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] data;
  logic [4:0] addr;
  logic [7:0] oUART;
  logic       ValTX;
  logic       busy;
  logic       frame_done;
  logic       cnt_err;

  answer_poller dut (
    .clk(clk), .rst(rst), .start(start), .tx_busy(tx_busy), .data(data),
    .addr(addr), .oUART(oUART), .ValTX(ValTX), .busy(busy),
    .frame_done(frame_done), .cnt_err(cnt_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0] resp_cnt = 8'd0;

  // Responder table: addr 0 = frame counter, n -> 10n, 16 -> 0x52, 17 -> 0x01
  function automatic logic [7:0] tbl(input int a, input logic [7:0] c);
    if (a == 0)       return c;
    else if (a <= 15) return 8'(a * 10);
    else if (a == 16) return 8'h52;
    else if (a == 17) return 8'h01;
    else              return 8'h00;
  endfunction

  function automatic logic [7:0] exp_byte(input int i, input logic [7:0] c);
    logic [7:0] x;
    if (i <= 17) return tbl(i, c);
    x = 8'h00;
    for (int k = 0; k <= 17; k++) x = x ^ tbl(k, c);
    return x;
  endfunction

  always @(posedge clk) data <= tbl(int'(addr), resp_cnt);

  // Wire monitor: records each byte, its strobe length and the preceding gap.
  logic [7:0] bytes_q[$];
  int         hi_q[$];
  int         gap_q[$];
  int         fd_cnt = 0;
  int         unstable = 0;
  logic       prev_val = 1'b0;
  logic [7:0] hold_byte = 8'h00;
  int         hi_cnt = 0;
  int         lo_cnt = 0;

  always @(negedge clk) begin
    if (ValTX && !prev_val) begin
      bytes_q.push_back(oUART);
      gap_q.push_back(lo_cnt);
      hold_byte = oUART;
      hi_cnt = 1;
      $display("byte #%0d addr=%0d data=0x%02h", bytes_q.size() - 1, addr, oUART);
    end else if (ValTX) begin
      hi_cnt++;
      if (oUART !== hold_byte) unstable++;
    end else if (prev_val) begin
      hi_q.push_back(hi_cnt);
      lo_cnt = 1;
    end else begin
      lo_cnt++;
    end
    if (frame_done === 1'b1) fd_cnt++;
    prev_val = ValTX;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic start_frame();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int fd0);
    int n;
    n = 0;
    while (fd_cnt == fd0 && n < 3000) begin
      step(1);
      n++;
    end
    chk("frame_done_seen", 32'(fd_cnt != fd0), 32'd1);
    step(3);
    chk("frame_done_once", 32'(fd_cnt - fd0), 32'd1);
    chk("busy_after_frame", 32'(busy), 32'd0);
  endtask

  task automatic check_frame(input int base, input logic [7:0] c);
    chk("byte_count", 32'(bytes_q.size() - base), 32'(FLEN));
    chk("strobe_count", 32'(hi_q.size() - base), 32'(FLEN));
    if (bytes_q.size() - base == FLEN && hi_q.size() - base == FLEN) begin
      for (int i = 0; i < FLEN; i++) begin
        chk($sformatf("byte%0d", i), 32'(bytes_q[base + i]), 32'(exp_byte(i, c)));
        chk($sformatf("hi_len%0d", i), 32'(hi_q[base + i]), 32'(VAL_CYC));
        if (i > 0)
          chk($sformatf("gap_ge%0d", i), 32'(gap_q[base + i] >= VAL_CYC), 32'd1);
      end
    end
  endtask

  task automatic full_frame(input logic [7:0] c);
    int base;
    int fd0;
    resp_cnt = c;
    base = bytes_q.size();
    fd0 = fd_cnt;
    start_frame();
    wait_done(fd0);
    check_frame(base, c);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int fd0;
    int n;
    int v;

    // Reset state
    step(3);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_oUART", 32'(oUART), 32'd0);
    chk("rst_ValTX", 32'(ValTX), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_cnt_err", 32'(cnt_err), 32'd0);
    rst = 1'b1;
    step(2);

    // Basic frame, then back-to-back good frame
    full_frame(8'h00);
    chk("cnt_err_f1", 32'(cnt_err), 32'd0);
    chk("oUART_stable", 32'(unstable), 32'd0);
    full_frame(8'h01);
    chk("cnt_err_f2", 32'(cnt_err), 32'd0);

    // Counter skip sets the sticky error; a later good step keeps it set
    full_frame(8'h03);
    chk("cnt_err_skip", 32'(cnt_err), 32'd1);
    full_frame(8'h04);
    chk("cnt_err_sticky", 32'(cnt_err), 32'd1);

    // Reset clears the error; FF -> 00 wrap is a valid step
    rst = 1'b0;
    step(2);
    chk("cnt_err_cleared", 32'(cnt_err), 32'd0);
    rst = 1'b1;
    step(1);
    full_frame(8'hFF);
    full_frame(8'h00);
    chk("cnt_err_wrap", 32'(cnt_err), 32'd0);

    // tx_busy stall at byte 5, with start pulses during the frame
    resp_cnt = 8'h01;
    base = bytes_q.size();
    fd0 = fd_cnt;
    start_frame();
    n = 0;
    while (addr !== 5'd5 && n < 2000) begin
      step(1);
      n++;
    end
    chk("reach_addr5", 32'(addr), 32'd5);
    tx_busy = 1'b1;
    start = 1'b1;
    v = 0;
    for (int k = 0; k < 20; k++) begin
      if (ValTX !== 1'b0 || addr !== 5'd5) v++;
      step(1);
      start = 1'b0;
    end
    chk("stall_violations", 32'(v), 32'd0);
    chk("stall_oUART", 32'(oUART), 32'h32);
    chk("stall_bytes", 32'(bytes_q.size() - base), 32'd5);
    tx_busy = 1'b0;
    wait_done(fd0);
    check_frame(base, 8'h01);
    step(30);
    chk("no_extra_frame", 32'(fd_cnt - fd0), 32'd1);
    chk("cnt_err_stall", 32'(cnt_err), 32'd0);

    // Asynchronous reset during byte 7's strobe
    resp_cnt = 8'h02;
    base = bytes_q.size();
    start_frame();
    n = 0;
    while (bytes_q.size() < base + 8 && n < 2000) begin
      step(1);
      n++;
    end
    step(1);
    chk("pre_rst_ValTX", 32'(ValTX), 32'd1);
    chk("pre_rst_addr", 32'(addr), 32'd7);
    #2 rst = 1'b0;
    #1;
    chk("arst_ValTX", 32'(ValTX), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_addr", 32'(addr), 32'd0);
    chk("arst_oUART", 32'(oUART), 32'd0);
    step(2);
    rst = 1'b1;
    step(2);
    full_frame(8'h40);
    chk("cnt_err_after_rst", 32'(cnt_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
